// File: rtl/write_buffer_pkg.sv
// Shared defaults and FSM encodings for the posted-write buffer between cache and ram.
package write_buffer_pkg;

    localparam int ADDR_WIDTH_DEF = 64;
    localparam int WORD_WIDTH_DEF = 64;
    localparam int DEPTH_BITS_DEF = 2;

    typedef enum logic [2:0] {
        D_IDLE,
        D_WR_ISSUE,
        D_WR_WAIT,
        D_RD_ISSUE,
        D_RD_WAIT
    } drain_state_t;

    typedef enum logic [1:0] {
        U_READY,
        U_HIT,
        U_MISS_WAIT
    } up_state_t;

endpackage

// File: rtl/write_buffer_wb_fifo.sv
// Circular store of posted writes with newest-first address match for read forwarding.
module write_buffer_wb_fifo
    import write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int DEPTH_BITS = DEPTH_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq,
    input  logic [ADDR_WIDTH-1:0] enq_addr,
    input  logic [WORD_WIDTH-1:0] enq_data,
    input  logic                  deq,
    input  logic [ADDR_WIDTH-1:0] match_addr,
    output logic                  hit,
    output logic [WORD_WIDTH-1:0] hit_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [WORD_WIDTH-1:0] head_data
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [WORD_WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH_BITS-1:0] head, tail, idx;
    logic [DEPTH_BITS:0]   count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PTR_ONE;
            if (deq) head <= head + PTR_ONE;
            if (enq && !deq)      count <= count + CNT_ONE;
            else if (deq && !enq) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail] <= enq_addr;
            data_mem[tail] <= enq_data;
        end
    end

    // Walk oldest to newest so the last match, i.e. the newest write, wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + DEPTH_BITS'(i);
            if (((DEPTH_BITS+1)'(i) < count) && (addr_mem[idx] == match_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer: absorbs cache write-backs, forwards buffered data to reads, drains to ram in order.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int DEPTH_BITS = DEPTH_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_din,
    output logic [WORD_WIDTH-1:0] mem_dout,
    input  logic                  mem_re,
    input  logic                  mem_we,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_WIDTH-1:0] ram_din,
    input  logic [WORD_WIDTH-1:0] ram_dout,
    output logic                  ram_re,
    output logic                  ram_we,
    input  logic                  ram_ready
);
    up_state_t    up_state, up_next;
    drain_state_t dr_state, dr_next;

    logic                  fifo_hit, fifo_full, fifo_empty;
    logic [WORD_WIDTH-1:0] fifo_hit_data, head_data, hit_hold;
    logic [ADDR_WIDTH-1:0] head_addr, miss_addr;
    logic                  wr_acc, rd_acc, miss_pending;
    logic                  issue_wr, issue_rd, wr_done, rd_done;

    assign mem_ready    = (up_state == U_READY) && !fifo_full;
    assign wr_acc       = mem_ready && mem_we;
    assign rd_acc       = mem_ready && mem_re && !mem_we;
    assign miss_pending = (up_state == U_MISS_WAIT);
    assign issue_wr     = (dr_state == D_WR_ISSUE) && ram_ready;
    assign issue_rd     = (dr_state == D_RD_ISSUE) && ram_ready;
    // The strobe is still high in the first wait cycle, which masks a stale ram_ready.
    assign wr_done      = (dr_state == D_WR_WAIT) && !ram_we && ram_ready;
    assign rd_done      = (dr_state == D_RD_WAIT) && !ram_re && ram_ready;

    write_buffer_wb_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_wb_fifo (
        .clk        (clk),
        .rst        (rst),
        .enq        (wr_acc),
        .enq_addr   (mem_addr),
        .enq_data   (mem_din),
        .deq        (wr_done),
        .match_addr (mem_addr),
        .hit        (fifo_hit),
        .hit_data   (fifo_hit_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_addr  (head_addr),
        .head_data  (head_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_state <= U_READY;
            dr_state <= D_IDLE;
        end else begin
            up_state <= up_next;
            dr_state <= dr_next;
        end
    end

    always_comb begin
        up_next = up_state;
        case (up_state)
            U_READY:     if (rd_acc) up_next = fifo_hit ? U_HIT : U_MISS_WAIT;
            U_HIT:       up_next = U_READY;
            U_MISS_WAIT: if (rd_done) up_next = U_READY;
            default:     up_next = U_READY;
        endcase
    end

    always_comb begin
        dr_next = dr_state;
        case (dr_state)
            D_IDLE: begin
                if (miss_pending)     dr_next = D_RD_ISSUE;
                else if (!fifo_empty) dr_next = D_WR_ISSUE;
            end
            D_WR_ISSUE: if (ram_ready) dr_next = D_WR_WAIT;
            D_WR_WAIT:  if (wr_done) dr_next = miss_pending ? D_RD_ISSUE : D_IDLE;
            D_RD_ISSUE: if (ram_ready) dr_next = D_RD_WAIT;
            D_RD_WAIT:  if (rd_done) dr_next = D_IDLE;
            default:    dr_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            mem_dout <= '0;
        end else begin
            ram_we <= issue_wr;
            ram_re <= issue_rd;
            if (issue_wr) begin
                ram_addr <= head_addr;
                ram_din  <= head_data;
            end else if (issue_rd) begin
                ram_addr <= miss_addr;
            end
            if (up_state == U_HIT) mem_dout <= hit_hold;
            else if (rd_done)      mem_dout <= ram_dout;
        end
    end

    // Captured at acceptance: the forwarded entry may drain before data is returned.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            miss_addr <= mem_addr;
            hit_hold  <= fifo_hit_data;
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Scenario bench for write_buffer with a stallable ram model and write/read scoreboards.
module tb_write_buffer;
    logic        clk, rst;
    logic [63:0] mem_addr, mem_din, mem_dout;
    logic        mem_re, mem_we, mem_ready;
    logic [63:0] ram_addr, ram_din, ram_dout;
    logic        ram_re, ram_we, ram_ready;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [63:0] exp_rd_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          we_pulses = 0;
    int          re_pulses = 0;
    int          we_at_re = 0;
    logic [63:0] ram_mem [1024];
    bit          ram_vld [1024];

    write_buffer #(.ADDR_WIDTH(64), .WORD_WIDTH(64), .DEPTH_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_re(mem_re), .mem_we(mem_we), .mem_ready(mem_ready),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_re(ram_re), .ram_we(ram_we), .ram_ready(ram_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ram model plus write-order scoreboard; strobes are one cycle wide so each spans one negedge.
    initial begin
        wr_t e;
        ram_dout = '0;
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                we_pulses++;
                ram_mem[ram_addr[9:0]] = ram_din;
                ram_vld[ram_addr[9:0]] = 1'b1;
                n_cmp++;
                if (exp_wr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ram_write: unexpected write addr=%h data=%h", ram_addr, ram_din);
                end else begin
                    e = exp_wr_q.pop_front();
                    if (ram_addr !== e.addr || ram_din !== e.data) begin
                        n_err++;
                        $display("FAIL ram_write: got addr=%h data=%h, want addr=%h data=%h",
                                 ram_addr, ram_din, e.addr, e.data);
                    end
                end
            end
            if (ram_re === 1'b1) begin
                re_pulses++;
                we_at_re = we_pulses;
                ram_dout = ram_vld[ram_addr[9:0]] ? ram_mem[ram_addr[9:0]] : '1;
            end
        end
    end

    task automatic do_write(input logic [63:0] a, input logic [63:0] d);
        int n = 0;
        while (mem_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mem_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL write_wait: mem_ready=%b, want 1 within 200 cycles", mem_ready);
        end else begin
            mem_addr = a;
            mem_din  = d;
            mem_we   = 1'b1;
            exp_wr_q.push_back('{addr: a, data: d});
            @(negedge clk);
            mem_we = 1'b0;
        end
    endtask

    task automatic do_read(input logic [63:0] a, output logic [63:0] d, output int low);
        int n = 0;
        low = 0;
        d = 'x;
        while (mem_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        mem_addr = a;
        mem_re   = 1'b1;
        @(negedge clk);
        mem_re = 1'b0;
        while (mem_ready !== 1'b1 && low < 200) begin
            low++;
            @(negedge clk);
        end
        if (mem_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL read_wait: mem_ready=%b, want 1 within 200 cycles", mem_ready);
        end
        d = mem_dout;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_wr_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_wr_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d writes outstanding, want 0", exp_wr_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_din = '0;
        ram_ready = 1'b1;
        @(negedge clk);
        n_cmp += 6;
        if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rst_mem_ready: got %b want 1", mem_ready); end
        if (ram_re !== 1'b0) begin n_err++; $display("FAIL rst_ram_re: got %b want 0", ram_re); end
        if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        if (mem_dout !== 64'h0) begin n_err++; $display("FAIL rst_mem_dout: got %h want 0", mem_dout); end
        if (ram_addr !== 64'h0) begin n_err++; $display("FAIL rst_ram_addr: got %h want 0", ram_addr); end
        if (ram_din !== 64'h0) begin n_err++; $display("FAIL rst_ram_din: got %h want 0", ram_din); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp += 2;
        if (mem_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", mem_ready); end
        if (ram_we !== 1'b0) begin n_err++; $display("FAIL idle_ram_we: got %b want 0", ram_we); end
    endtask

    task automatic test_forward_hit();
        logic [63:0] d, e;
        int low;
        int re0 = re_pulses;
        exp_rd_q.push_back(64'h0123456789abcdef);
        do_write(64'd1, 64'h0123456789abcdef);
        do_read(64'd1, d, low);
        e = exp_rd_q.pop_front();
        n_cmp += 2;
        if (d !== e) begin n_err++; $display("FAIL hit_data: got %h want %h", d, e); end
        if (low !== 1) begin n_err++; $display("FAIL hit_latency: ready low %0d cycles, want 1", low); end
        wait_drain();
        n_cmp += 2;
        if (re_pulses !== re0) begin n_err++; $display("FAIL hit_no_ram_re: got %0d pulses want %0d", re_pulses, re0); end
        if (ram_mem[1] !== 64'h0123456789abcdef) begin n_err++; $display("FAIL hit_ram_word: got %h want 0123456789abcdef", ram_mem[1]); end
    endtask

    task automatic test_full_drain();
        int we0 = we_pulses;
        int n = 0;
        ram_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_write(64'(i), 64'(10 + i));
        n_cmp++;
        if (mem_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", mem_ready); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (we_pulses !== we0) begin n_err++; $display("FAIL stalled_we: got %0d pulses want %0d", we_pulses - we0, 0); end
        ram_ready = 1'b1;
        while (mem_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp += 2;
        if (mem_ready !== 1'b1) begin n_err++; $display("FAIL unfull_ready: got %b want 1", mem_ready); end
        if (we_pulses - we0 !== 1) begin n_err++; $display("FAIL ready_after_first: got %0d writes want 1", we_pulses - we0); end
        wait_drain();
        n_cmp++;
        if (we_pulses - we0 !== 4) begin n_err++; $display("FAIL full_write_count: got %0d want 4", we_pulses - we0); end
    endtask

    task automatic test_forward_newest();
        logic [63:0] d, e;
        int low;
        ram_ready = 1'b0;
        do_write(64'd257, 64'd123);
        do_write(64'd257, 64'd456);
        exp_rd_q.push_back(64'd456);
        do_read(64'd257, d, low);
        e = exp_rd_q.pop_front();
        n_cmp += 2;
        if (d !== e) begin n_err++; $display("FAIL newest_data: got %0d want %0d", d, e); end
        if (low !== 1) begin n_err++; $display("FAIL newest_latency: ready low %0d cycles, want 1", low); end
        ram_ready = 1'b1;
        wait_drain();
        n_cmp++;
        if (ram_mem[257] !== 64'd456) begin n_err++; $display("FAIL newest_ram_word: got %0d want 456", ram_mem[257]); end
    endtask

    task automatic test_miss_order();
        logic [63:0] d, e;
        int low;
        int we0, re0;
        for (int i = 0; i < 1024; i++) ram_vld[i] = 1'b0;
        we0 = we_pulses;
        re0 = re_pulses;
        ram_ready = 1'b1;
        do_write(64'd8, 64'h88);
        do_write(64'd9, 64'h99);
        exp_rd_q.push_back(64'hFFFFFFFFFFFFFFFF);
        do_read(64'd0, d, low);
        e = exp_rd_q.pop_front();
        n_cmp += 4;
        if (d !== e) begin n_err++; $display("FAIL miss_data: got %h want %h", d, e); end
        if ((low > 2) !== 1'b1) begin n_err++; $display("FAIL miss_latency: ready low %0d cycles, want more than 2", low); end
        if (re_pulses - re0 !== 1) begin n_err++; $display("FAIL miss_re_count: got %0d want 1", re_pulses - re0); end
        if (we_at_re - we0 !== 1) begin n_err++; $display("FAIL miss_order: %0d writes before ram_re, want 1", we_at_re - we0); end
        wait_drain();
        n_cmp++;
        if (we_pulses - we0 !== 2) begin n_err++; $display("FAIL miss_write_count: got %0d want 2", we_pulses - we0); end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] d, e;
        int low;
        int we1, re0;
        ram_ready = 1'b0;
        do_write(64'd30, 64'h30);
        do_write(64'd9, 64'hAA);
        do_write(64'd31, 64'h31);
        ram_ready = 1'b1;
        @(negedge clk);
        ram_ready = 1'b0;
        n_cmp++;
        if (ram_we !== 1'b1) begin n_err++; $display("FAIL midflight_we: got %b want 1", ram_we); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp += 2;
        if (ram_we !== 1'b0) begin n_err++; $display("FAIL async_rst_we: got %b want 0", ram_we); end
        if (mem_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready: got %b want 1", mem_ready); end
        exp_wr_q.delete();
        @(negedge clk);
        rst = 1'b1;
        ram_ready = 1'b1;
        we1 = we_pulses;
        re0 = re_pulses;
        exp_rd_q.push_back(64'h99);
        do_read(64'd9, d, low);
        e = exp_rd_q.pop_front();
        repeat (6) @(negedge clk);
        n_cmp += 3;
        if (d !== e) begin n_err++; $display("FAIL post_rst_read: got %h want %h", d, e); end
        if (re_pulses - re0 !== 1) begin n_err++; $display("FAIL post_rst_miss: got %0d ram_re want 1", re_pulses - re0); end
        if (we_pulses !== we1) begin n_err++; $display("FAIL discarded_writes: got %0d extra writes want 0", we_pulses - we1); end
    endtask

    initial begin
        test_reset();
        test_forward_hit();
        test_full_drain();
        test_forward_newest();
        test_miss_order();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
